// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding/state encodings and scoreboard entry layout for pipeline_hazard_ctrl.
package hazard_pkg;
  localparam int SB_REG_W = 5;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  typedef enum logic [1:0] {IDLE, DRAIN, SYSP, REL} state_t;
  typedef struct packed {
    logic valid;
    logic [SB_REG_W-1:0] dest;
    logic load;
  } sb_entry_t;
  function automatic logic sb_match(input logic used, input logic [SB_REG_W-1:0] src, input sb_entry_t e);
    return used && src != '0 && e.valid && e.dest == src;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EXE/MEM in-flight writer shift register with per-operand match bits.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                hold,
  input  logic                issue,
  input  logic [SB_REG_W-1:0] dest,
  input  logic                load,
  input  logic [SB_REG_W-1:0] rs,
  input  logic [SB_REG_W-1:0] rt,
  input  logic                use_rs,
  input  logic                use_rt,
  output logic                exe_a,
  output logic                exe_b,
  output logic                mem_a,
  output logic                mem_b,
  output logic                exe_valid,
  output logic                exe_load,
  output logic                mem_valid
);
  sb_entry_t exe_q, mem_q;
  logic unused_mem_load;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      exe_q <= '0;
      mem_q <= '0;
    end else if (!hold) begin
      mem_q <= exe_q;
      exe_q <= '{issue, dest, load};
    end
  assign exe_a = sb_match(use_rs, rs, exe_q);
  assign exe_b = sb_match(use_rt, rt, exe_q);
  assign mem_a = sb_match(use_rs, rs, mem_q);
  assign mem_b = sb_match(use_rt, rt, mem_q);
  assign exe_valid = exe_q.valid;
  assign exe_load = exe_q.load;
  assign mem_valid = mem_q.valid;
  assign unused_mem_load = mem_q.load;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: decode-stage forwarding selects, load-use stall and syscall drain sequencer.
// Operand forwarding is built only when HAZARD_OPERAND_FWD_EN is defined; otherwise any dependency stalls.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             HOLD_IN,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic [REG_W-1:0] ID_dest,
  input  logic             ID_reg_write,
  input  logic             ID_load,
  input  logic             ID_syscall,
  output logic [1:0]       Select_A,
  output logic [1:0]       Select_B,
  output logic             Stall,
  output logic             Bubble,
  output logic             SYS,
  output logic             Busy
);
  state_t state;
  logic exe_a, exe_b, mem_a, mem_b, exe_valid, exe_load, mem_valid;
  logic load_use, hazard, drained, issue;
  hazard_scoreboard u_sb (
    .CLK(CLK),
    .RESET(RESET),
    .hold(HOLD_IN),
    .issue(issue),
    .dest(ID_dest),
    .load(ID_load),
    .rs(ID_rs),
    .rt(ID_rt),
    .use_rs(ID_use_rs),
    .use_rt(ID_use_rt),
    .exe_a(exe_a),
    .exe_b(exe_b),
    .mem_a(mem_a),
    .mem_b(mem_b),
    .exe_valid(exe_valid),
    .exe_load(exe_load),
    .mem_valid(mem_valid)
  );
  always_comb begin
    load_use = (exe_a || exe_b) && exe_load;
`ifdef HAZARD_OPERAND_FWD_EN
    hazard = load_use;
    Select_A = exe_a && !exe_load ? FWD_ALU : mem_a ? FWD_MEM : FWD_RF;
    Select_B = exe_b && !exe_load ? FWD_ALU : mem_b ? FWD_MEM : FWD_RF;
`else
    hazard = load_use || exe_a || exe_b || mem_a || mem_b;
    Select_A = FWD_RF;
    Select_B = FWD_RF;
`endif
    drained = !exe_valid && !mem_valid;
    Stall = state == DRAIN || state == SYSP || (state == IDLE && (hazard || ID_syscall));
    Bubble = Stall;
    Busy = state != IDLE;
    // the released syscall never enters the scoreboard
    issue = ID_reg_write && ID_dest != '0 && !Bubble && state != REL;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      SYS <= 1'b0;
    end else if (!HOLD_IN) begin
      SYS <= state == DRAIN && drained;
      case (state)
        IDLE:    state <= ID_syscall && !hazard ? DRAIN : IDLE;
        DRAIN:   state <= drained ? SYSP : DRAIN;
        SYSP:    state <= REL;
        default: state <= IDLE;
      endcase
    end
endmodule
